// File: rtl/seq_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
// State encoding is fixed so that benches can decode it if needed.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_W   = 8;
  localparam int DEF_LW  = 4;
  localparam int DEF_RW  = 4;
  localparam int DEF_GAP = 2;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern generator: shifts a latched pattern out MSB-first,
// optionally repeating it with a fixed idle gap between frames.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int LW  = DEF_LW,
  parameter int RW  = DEF_RW,
  parameter int GAP = DEF_GAP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [RW-1:0] reps,
  output logic          x,
  output logic          valid,
  output logic          busy,
  output logic          done
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LW-1:0] W_L = LW'(W);

  state_t        state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [LW-1:0] len_in;
  logic [LW-1:0] sel;
  logic          last_bit;
  logic          x_bit;

  assign len_in   = (len > W_L) ? W_L : len;
  assign sel      = len_q - LW'(1) - idx_q;
  assign last_bit = (idx_q == len_q - LW'(1));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          pat_d   = pattern;
          len_d   = len_in;
          rep_d   = reps;
          idx_d   = '0;
          gap_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          idx_d = idx_q + LW'(1);
        end else if (rep_q == '0) begin
          state_d = ST_DONE;
        end else begin
          rep_d   = rep_q - RW'(1);
          idx_d   = '0;
          gap_d   = '0;
          state_d = (GAP > 0) ? ST_GAP : ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
    end
  end

  // Index mux instead of a destructive shifter, so repeats need no reload.
  always_comb begin
    x_bit = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (LW'(i) == sel) x_bit = pat_q[i];
    end
  end

  assign valid = (state_q == ST_SHIFT);
  assign x     = valid & x_bit;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: each cycle's {x,valid,busy,done}
// is predicted when stimulus is driven and compared on the falling edge.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       x, valid, busy, done;

  int tests  = 0;
  int failed = 0;

  logic [3:0] sb[$];

  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .pattern(pattern), .len(len), .reps(reps),
    .x(x), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: expected per-cycle outputs of one transaction.
  task automatic push_txn(input logic [7:0] p, input int l, input int r);
    int lc;
    lc = (l > 8) ? 8 : l;
    for (int k = 0; k <= r; k++) begin
      for (int i = lc - 1; i >= 0; i--) sb.push_back({p[i], 3'b110});
      if (k < r) for (int g = 0; g < 2; g++) sb.push_back(4'b0010);
    end
    sb.push_back(4'b0011);
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; pattern = 8'hFF; len = 4'd4;
    @(negedge clk);
    obs = {x, valid, busy, done};
    tests++;
    if (obs !== 4'b0000) begin
      failed++;
      $display("FAIL reset_start got %b want %b", obs, 4'b0000);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    obs = {x, valid, busy, done};
    tests++;
    if (obs !== 4'b0000) begin
      failed++;
      $display("FAIL reset_idle got %b want %b", obs, 4'b0000);
    end
  endtask

  task automatic test_single();
    logic [3:0] obs, exp;
    logic [3:0] det;
    int busy_n;
    det = '0; busy_n = 0;
    @(negedge clk);
    start = 1'b1; pattern = 8'h0A; len = 4'd4; reps = 4'd0;
    push_txn(8'h0A, 4, 0);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      if (valid) det = {det[2:0], x};
      if (busy) busy_n++;
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL single_0A got %b want %b", obs, exp);
      end
    end
    tests++;
    if (busy_n != 5) begin
      failed++;
      $display("FAIL single_busy_cycles got %0d want 5", busy_n);
    end
    tests++;
    if (det !== 4'b1010) begin
      failed++;
      $display("FAIL loopback_1010 got %b want 1010", det);
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] obs, exp;
    @(negedge clk);
    start = 1'b1; pattern = 8'hA5; len = 4'd8; reps = 4'd0;
    push_txn(8'hA5, 8, 0);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL msb_A5 got %b want %b", obs, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic [3:0] obs, exp;
    int busy_n;
    busy_n = 0;
    @(negedge clk);
    start = 1'b1; pattern = 8'h0A; len = 4'd4; reps = 4'd2;
    push_txn(8'h0A, 4, 2);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      pattern = 8'h33; len = 4'd2; reps = 4'd0;
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      if (busy) busy_n++;
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL repeat_gap got %b want %b", obs, exp);
      end
    end
    tests++;
    if (busy_n != 17) begin
      failed++;
      $display("FAIL repeat_busy_cycles got %0d want 17", busy_n);
    end
  endtask

  task automatic test_len_zero_and_clamp();
    logic [3:0] obs, exp;
    @(negedge clk);
    start = 1'b1; pattern = 8'hFF; len = 4'd0; reps = 4'd3;
    for (int i = 0; i < 4; i++) sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL len_zero got %b want %b", obs, exp);
      end
    end
    @(negedge clk);
    start = 1'b1; pattern = 8'hC3; len = 4'd15; reps = 4'd0;
    push_txn(8'hC3, 15, 0);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL len_clamp got %b want %b", obs, exp);
      end
    end
  endtask

  task automatic test_start_during_shift();
    logic [3:0] obs, exp;
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1; pattern = 8'hA5; len = 4'd8; reps = 4'd0;
    push_txn(8'hA5, 8, 0);
    sb.push_back(4'b0000);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      start = (n == 3);
      if (n == 3) begin
        pattern = 8'hFF; len = 4'd3;
      end
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL start_in_shift got %b want %b", obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1; pattern = 8'h0A; len = 4'd4; reps = 4'd0;
    push_txn(8'h0A, 4, 0);
    sb.push_back(4'b0000);
    push_txn(8'h0A, 4, 0);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      if (n == 7) start = 1'b0;
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL back_to_back cyc%0d got %b want %b", n, obs, exp);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [3:0] obs, exp;
    @(negedge clk);
    start = 1'b1; pattern = 8'h0A; len = 4'd4; reps = 4'd1;
    sb.push_back(4'b1110);
    sb.push_back(4'b0110);
    sb.push_back(4'b0000);
    sb.push_back(4'b0000);
    sb.push_back(4'b0000);
    for (int n = 1; sb.size() > 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (n == 2);
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL rst_mid cyc%0d got %b want %b", n, obs, exp);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; pattern = 8'h0A; len = 4'd4; reps = 4'd0;
    push_txn(8'h0A, 4, 0);
    sb.push_back(4'b0000);
    while (sb.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp = sb.pop_front();
      obs = {x, valid, busy, done};
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL rst_recover got %b want %b", obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_msb_first();
    test_repeat();
    test_len_zero_and_clamp();
    test_start_during_shift();
    test_back_to_back();
    test_rst_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern generator: the transmit side of the team's serial sequence detectors. It accepts a parallel pattern of programmable length, shifts it out MSB-first one bit per clock, and optionally repeats it with a fixed idle gap between frames. It drives the single-bit `x` stimulus line that feeds the Moore 1010 sequence detector, both in system and in loop-back benches.

## Interface
- `W`, 8: maximum pattern length in bits.
- `LW`, 4: width of `len`; must hold the value W, i.e. $clog2(W+1).
- `RW`, 4: width of the repeat count.
- `GAP`, 2: idle cycles inserted between repeated frames; 0 means back-to-back.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `pattern`  in  W  bits to send; bit `len-1` goes first.
- `len`  in  LW  number of bits per frame, 1..W.
- `reps`  in  RW  extra repetitions: frame is sent `reps+1` times.
- `x`  out  1  serial data, registered.
- `valid`  out  1  `x` carries a pattern bit this cycle.
- `busy`  out  1  high from the cycle after start acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse after the final bit.

## Operation
- FSM states: IDLE, SHIFT, GAP, DONE. All outputs are decoded from registered state and datapath (Moore), never from the current-cycle inputs.
- **IDLE**
  - `x=0`, `valid=0`, `busy=0`, `done=0`.
  - `start=1` with `len` in 1..W: latch `pattern`, `len` and `reps`; clear the bit index; go to SHIFT.
  - `start=1` with `len=0`: ignored, stay in IDLE.
  - `len>W`: clamp to W.
- **SHIFT**
  - `valid=1`, `busy=1`, `x = pat_q[len_q-1-idx]`.
  - Each cycle `idx` increments.
  - At `idx==len_q-1` with `rep_left==0`: go to DONE.
  - Otherwise: decrement `rep_left`, clear `idx`, go to GAP if GAP>0, else stay in SHIFT (back-to-back frames).
- **GAP**
  - `x=0`, `valid=0`, `busy=1`.
  - Stay exactly GAP cycles, counted by the gap counter, then return to SHIFT with `idx=0`.
- **DONE**
  - `done=1`, `busy=1`, `x=0`, `valid=0`.
  - Always goes to IDLE on the next cycle.
- `start` outside IDLE is ignored; it is not queued. Inputs are latched at acceptance, so changes to `pattern`, `len` or `reps` while busy have no effect.
- Counter widths:
  - `idx`: LW bits.
  - `rep_left`: RW bits.
  - gap counter: $clog2(GAP+1), minimum 1 bit.
  - No counter ever wraps; the terminal compares above bound every count.

## Timing
- Reset: `rst=1` at an edge forces IDLE and clears `x`, `valid`, `busy`, `done` and all counters on that edge, including mid-frame or mid-gap. No partial frame continues after reset; the next `start` is accepted on the first edge with `rst=0`.
- Latency: `start` sampled at edge k puts the first bit on `x` with `valid=1` during cycle k+1.
- Frame length: a frame occupies `len` consecutive `valid` cycles.
- Total busy cycles: `(reps+1)*len + reps*GAP + 1`, where the +1 is DONE.
- Back-to-back transactions: `done` appears in the cycle after the last bit. IDLE follows, so the earliest next `start` is sampled at the edge ending the DONE cycle, plus one cycle. This gives a minimum 2-cycle spacing between the last bit of one transaction and the first bit of the next.
- Simultaneous `rst` and `start`: reset wins.

## Structure
- Package `seq_tx_pkg` holds:
  - `state_t` enum (IDLE=0, SHIFT=1, GAP=2, DONE=3), 2 bits.
  - Default constants for W, LW, RW and GAP.
- Single module, no sub-module. The pattern register plus index mux is preferred over a destructive shift register so that repeats need no reload.

## Test plan
- `pattern=8'h0A`, `len=4`, `reps=0`, one-cycle `start`:
  - `x` = 1,0,1,0 with `valid=1` over 4 cycles.
  - `done` pulses in cycle 5; `busy` high for 5 cycles.
  - Loop-back into the 1010 detector raises `y`.
- `pattern=8'hA5`, `len=8`, `reps=0`: `x` = 1,0,1,0,0,1,0,1, MSB first.
- `pattern=8'h0A`, `len=4`, `reps=2`, `GAP=2`:
  - Output is 1010, 00 with `valid=0`, 1010, 00, 1010, then `done`.
  - `busy` is high for 17 cycles.
- Robustness:
  - `start` with `len=0`: no `valid`, no `busy`, no `done`.
  - `start` pulsed during SHIFT: ignored; the frame completes unchanged.
- `rst` asserted on the 2nd bit of a `reps=1` frame:
  - The next cycle shows all outputs 0 and IDLE.
  - A new `start` then produces a clean full frame.
